// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: condition codes,
// FSM state encoding and default flush length.
package branch_redirect_unit_pkg;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int FLUSH_CNT_W      = 3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_redirect_unit_cmp.sv
// Branch condition evaluator: decides taken/not-taken from the two
// source operands and funct3. Reserved codes evaluate as not-taken.
module branch_cmp
    import branch_redirect_unit_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Execute-stage redirect: resolves branch/jal/jalr targets, issues a
// one-cycle redirect strobe and holds flush_out for FLUSH_CYCLES cycles.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | accepting execute-stage instructions
//   ST_FLUSH | squashing wrong path; flush counter counts down to 0
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic [2:0]       ex_funct3,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    output logic [31:0]      nagout,
    output logic             branch_enable,
    output logic             jal_en,
    output logic             jalr_en,
    output logic             flush_out,
    output logic [31:0]      link_addr,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]            nagout_q, nagout_d;
    logic [31:0]            link_addr_q, link_addr_d;
    logic                   branch_enable_q, branch_enable_d;
    logic                   jal_en_q, jal_en_d;
    logic                   jalr_en_q, jalr_en_d;
    logic                   misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0]       redirect_cnt_q, redirect_cnt_d;

    logic        cond_taken;
    logic        accept;
    logic        taken;
    logic        aligned;
    logic        redirect;
    logic [31:0] target;

    branch_cmp u_cmp (
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .funct3 (ex_funct3),
        .taken  (cond_taken)
    );

    always_comb begin
        accept   = ex_valid && !stall && (state_q == ST_IDLE);
        // jalr clears bit 0 of the sum; branch and jal are pc-relative
        target   = is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        taken    = is_jalr || is_jal || (is_branch && cond_taken);
        aligned  = (target[1:0] == 2'b00);
        redirect = accept && taken && aligned;

        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        nagout_d        = nagout_q;
        link_addr_d     = link_addr_q;
        redirect_cnt_d  = redirect_cnt_q;
        branch_enable_d = 1'b0;
        jal_en_d        = 1'b0;
        jalr_en_d       = 1'b0;
        misalign_err_d  = accept && taken && !aligned;

        if (accept && (is_jal || is_jalr)) begin
            link_addr_d = ex_pc + 32'd4;
        end

        if (redirect) begin
            nagout_d        = target;
            jalr_en_d       = is_jalr;
            jal_en_d        = !is_jalr && is_jal;
            branch_enable_d = !is_jalr && !is_jal;
            if (redirect_cnt_q != '1) begin
                redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            flush_cnt_q     <= '0;
            nagout_q        <= '0;
            link_addr_q     <= '0;
            branch_enable_q <= 1'b0;
            jal_en_q        <= 1'b0;
            jalr_en_q       <= 1'b0;
            misalign_err_q  <= 1'b0;
            redirect_cnt_q  <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            nagout_q        <= nagout_d;
            link_addr_q     <= link_addr_d;
            branch_enable_q <= branch_enable_d;
            jal_en_q        <= jal_en_d;
            jalr_en_q       <= jalr_en_d;
            misalign_err_q  <= misalign_err_d;
            redirect_cnt_q  <= redirect_cnt_d;
        end
    end

    // flush_out decodes the state flop so an async reset drops it at once
    assign flush_out     = (state_q == ST_FLUSH);
    assign nagout        = nagout_q;
    assign link_addr     = link_addr_q;
    assign branch_enable = branch_enable_q;
    assign jal_en        = jal_en_q;
    assign jalr_en       = jalr_en_q;
    assign misalign_err  = misalign_err_q;
    assign redirect_cnt  = redirect_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: stimulus pushes expected
// redirect events, a negedge monitor pops and compares them.
module tb_branch_redirect_unit;

    localparam int K_BR  = 0;
    localparam int K_JAL = 1;
    localparam int K_JR  = 2;
    localparam int K_MIS = 3;

    typedef struct {
        int          kind;
        logic [31:0] tgt;
        logic [31:0] link;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_valid2 = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0, ex_rs2 = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;

    logic [31:0] nagout, link_addr;
    logic        branch_enable, jal_en, jalr_en, flush_out, misalign_err;
    logic [15:0] redirect_cnt;

    logic [31:0] nagout2, link_addr2;
    logic        branch_enable2, jal_en2, jalr_en2, flush_out2, misalign_err2;
    logic [1:0]  redirect_cnt2;

    always #5 clk = ~clk;

    branch_redirect_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_funct3(ex_funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .nagout(nagout), .branch_enable(branch_enable), .jal_en(jal_en), .jalr_en(jalr_en),
        .flush_out(flush_out), .link_addr(link_addr), .misalign_err(misalign_err),
        .redirect_cnt(redirect_cnt)
    );

    branch_redirect_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid2), .stall(stall),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_funct3(ex_funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .nagout(nagout2), .branch_enable(branch_enable2), .jal_en(jal_en2), .jalr_en(jalr_en2),
        .flush_out(flush_out2), .link_addr(link_addr2), .misalign_err(misalign_err2),
        .redirect_cnt(redirect_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] tgt, input logic [31:0] link);
        exp_t e;
        e.kind = kind;
        e.tgt  = tgt;
        e.link = link;
        sb.push_back(e);
        if (kind != K_MIS) exp_cnt++;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic br, input logic jal,
                          input logic jalr);
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_rs2 = rs2; ex_funct3 = f3;
        is_branch = br; is_jal = jal; is_jalr = jalr;
    endtask

    // present for one edge, then withdraw
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] f3, input logic br, input logic jal,
                         input logic jalr);
        set_in(pc, imm, rs1, rs2, f3, br, jal, jalr);
        ex_valid = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    endtask

    task automatic flush_window(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({name, "_flush_hi"}, 32'(flush_out), 32'd1);
        end
        @(negedge clk);
        chk({name, "_flush_lo"}, 32'(flush_out), 32'd0);
        chk({name, "_cnt"}, 32'(redirect_cnt), 32'(exp_cnt));
    endtask

    task automatic quiet_window(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({name, "_no_flush"}, 32'(flush_out), 32'd0);
        end
        chk({name, "_cnt"}, 32'(redirect_cnt), 32'(exp_cnt));
    endtask

    // monitor: every strobe or misalign pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            int   nstb;
            int   act_kind;
            exp_t e;
            nstb = int'(branch_enable) + int'(jal_en) + int'(jalr_en);
            if (nstb > 1) chk("strobe_onehot", 32'(nstb), 32'd1);
            if (nstb > 0 || misalign_err) begin
                act_kind = misalign_err ? K_MIS : jalr_en ? K_JR : jal_en ? K_JAL : K_BR;
                if (sb.size() == 0) begin
                    chk("unexpected_event_kind", 32'(act_kind), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(act_kind), 32'(e.kind));
                    if (e.kind == K_MIS) chk("misalign_no_strobe", 32'(nstb), 32'd0);
                    else chk("nagout", nagout, e.tgt);
                    if (e.kind == K_JAL || e.kind == K_JR) chk("link_addr", link_addr, e.link);
                end
            end
        end
    end

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_nagout", nagout, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_strobes", 32'({branch_enable, jal_en, jalr_en, misalign_err}), 32'd0);
        chk("rst_cnt", 32'(redirect_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // beq taken
        expect_ev(K_BR, 32'h120, 32'h0);
        issue(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, 1'b0);
        flush_window("beq", 2);

        // jalr aligned: (0x203+1)&~1 = 0x204
        expect_ev(K_JR, 32'h204, 32'h404);
        issue(32'h400, 32'h1, 32'h203, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        flush_window("jalr", 2);
        chk("jalr_link_hold", link_addr, 32'h404);

        // jalr misaligned target 0x202
        expect_ev(K_MIS, 32'h0, 32'h0);
        issue(32'h500, 32'h0, 32'h202, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        quiet_window("jalr_mis", 3);
        chk("mis_nagout_hold", nagout, 32'h204);

        // blt signed: -1 < 1 taken
        expect_ev(K_BR, 32'h640, 32'h0);
        issue(32'h600, 32'h40, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b1, 1'b0, 1'b0);
        flush_window("blt", 2);

        // bltu: 0xFFFFFFFF < 1 false
        issue(32'h680, 32'h40, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b1, 1'b0, 1'b0);
        quiet_window("bltu", 3);
        chk("bltu_nagout_hold", nagout, 32'h640);

        // funct3 010 reserved, equal operands still not taken
        issue(32'h6C0, 32'h40, 32'h7, 32'h7, 3'b010, 1'b1, 1'b0, 1'b0);
        quiet_window("f3_010", 3);

        // bge equal, negative offset: 0x700-0x10
        expect_ev(K_BR, 32'h6F0, 32'h0);
        issue(32'h700, 32'hFFFF_FFF0, 32'd5, 32'd5, 3'b101, 1'b1, 1'b0, 1'b0);
        flush_window("bge", 2);

        // bgeu 1 >= 0xFFFFFFFF false
        issue(32'h740, 32'h10, 32'h1, 32'hFFFF_FFFF, 3'b111, 1'b1, 1'b0, 1'b0);
        quiet_window("bgeu", 3);

        // bne taken
        expect_ev(K_BR, 32'h808, 32'h0);
        issue(32'h800, 32'h8, 32'h1, 32'h2, 3'b001, 1'b1, 1'b0, 1'b0);
        flush_window("bne", 2);

        // all class flags: jalr wins
        expect_ev(K_JR, 32'h1004, 32'h904);
        issue(32'h900, 32'h4, 32'h1000, 32'h0, 3'b000, 1'b1, 1'b1, 1'b1);
        flush_window("prio", 2);

        // target wraps modulo 2^32
        expect_ev(K_JAL, 32'h0000_0010, 32'hFFFF_FFF4);
        issue(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        flush_window("wrap", 2);

        // jal, then taken branches held valid through both flush cycles
        expect_ev(K_JAL, 32'hB00, 32'hA04);
        issue(32'hA00, 32'h100, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        set_in(32'hA40, 32'h40, 32'd3, 32'd3, 3'b000, 1'b1, 1'b0, 1'b0);
        ex_valid = 1'b1;
        @(negedge clk);
        chk("drop_flush1", 32'(flush_out), 32'd1);
        @(negedge clk);
        chk("drop_flush2", 32'(flush_out), 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        is_branch = 1'b0;
        quiet_window("drop", 3);
        chk("drop_nagout", nagout, 32'hB00);

        // stall on the would-be accept cycle
        set_in(32'hB80, 32'h80, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        ex_valid = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        stall = 1'b0;
        is_jal = 1'b0;
        quiet_window("stall", 3);
        chk("stall_link_hold", link_addr, 32'hA04);

        // reset during second flush cycle
        expect_ev(K_BR, 32'hC10, 32'h0);
        issue(32'hC00, 32'h10, 32'd9, 32'd9, 3'b000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid_flush1", 32'(flush_out), 32'd1);
        @(posedge clk);
        #2;
        chk("rstmid_flush2", 32'(flush_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_flush_async", 32'(flush_out), 32'd0);
        chk("rstmid_nagout", nagout, 32'h0);
        chk("rstmid_link", link_addr, 32'h0);
        chk("rstmid_cnt", 32'(redirect_cnt), 32'd0);
        chk("rstmid_strobes", 32'({branch_enable, jal_en, jalr_en, misalign_err}), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        quiet_window("post_rst", 2);

        // 2-bit counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            set_in(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, 1'b0);
            ex_valid2 = 1'b1;
            @(posedge clk);
            #1;
            ex_valid2 = 1'b0;
            is_branch = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("sat_cnt_%0d", k), 32'(redirect_cnt2), (k > 3) ? 32'd3 : 32'(k));
        end
        chk("sat_nagout", nagout2, 32'h120);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
